// File: rtl/dbus_timer_pkg.sv
// dbus_timer_pkg
//   Shared definitions for the memory-mapped machine timer: register word
//   offsets inside the 32-byte window, CTRL bit positions, reset constants,
//   the bus FSM state type and a byte-mask merge helper.
package dbus_timer_pkg;

    // Byte-enable width of the data bus.
    localparam int unsigned DBUS_MASK = 4;

    // Register offsets as word indices (addr[4:2]).
    localparam logic [2:0] OFF_CTRL        = 3'd0;  // 0x00
    localparam logic [2:0] OFF_PRESCALE    = 3'd1;  // 0x04
    localparam logic [2:0] OFF_MTIME_LO    = 3'd2;  // 0x08
    localparam logic [2:0] OFF_MTIME_HI    = 3'd3;  // 0x0C
    localparam logic [2:0] OFF_MTIMECMP_LO = 3'd4;  // 0x10
    localparam logic [2:0] OFF_MTIMECMP_HI = 3'd5;  // 0x14

    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_INT_EN_BIT = 1;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } bus_state_e;

    // Replace the bytes of old_val selected by mask with those of new_val.
    function automatic logic [31:0] apply_mask(input logic [31:0]          old_val,
                                               input logic [31:0]          new_val,
                                               input logic [DBUS_MASK-1:0] mask);
        logic [31:0] res;
        res = old_val;
        for (int n = 0; n < DBUS_MASK; n++) begin
            if (mask[n]) begin
                res[8*n +: 8] = new_val[8*n +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dbus_timer_tick_gen.sv
// timer_tick_gen
//   Prescaler for the machine timer. While en=1 the counter runs
//   0..prescale and tick pulses for one cycle on the terminal count, so
//   prescale=0 ticks every cycle. en=0 freezes the counter without clearing.
// Ports:
//   clk       system clock
//   rst       asynchronous active-high reset
//   en        count enable (CTRL.EN)
//   prescale  reload value
//   tick      one-cycle increment strobe for mtime
module timer_tick_gen #(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt_q;

    // >= so that lowering prescale below a frozen count still terminates.
    assign tick = en && (cnt_q >= prescale);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/dbus_timer.sv
// dbus_timer
//   Machine timer responder on the core data bus. Holds a 64-bit mtime
//   counter advanced by a prescaler, a 64-bit mtimecmp and a level timer
//   interrupt. Each request is acknowledged with a one-cycle ready strobe
//   after WAIT_CYCLES wait states; out-of-window accesses are acknowledged,
//   reads return 0 and writes are dropped.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   I_dbus_req      request valid, held until O_dbus_ready
//   I_dbus_we       1 = write, 0 = read
//   I_dbus_addr     byte address (bits [1:0] ignored)
//   I_dbus_data     write data
//   I_dbus_mask     write byte enables
//   O_dbus_data     read data, valid while O_dbus_ready=1
//   O_dbus_ready    completion strobe
//   O_timer_int     timer interrupt (INT_EN & mtime >= mtimecmp)
module dbus_timer
    import dbus_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned PRESCALE_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 I_dbus_req,
    input  logic                 I_dbus_we,
    input  logic [31:0]          I_dbus_addr,
    input  logic [31:0]          I_dbus_data,
    input  logic [DBUS_MASK-1:0] I_dbus_mask,
    output logic [31:0]          O_dbus_data,
    output logic                 O_dbus_ready,
    output logic                 O_timer_int
);

    localparam logic [2:0] WAIT_INIT = (WAIT_CYCLES == 0) ? 3'd0 : 3'(WAIT_CYCLES - 1);

    // Bus FSM state and latched request.
    bus_state_e           state_q;
    logic [2:0]           wait_cnt_q;
    logic                 ready_q;
    logic                 we_q;
    logic                 hit_q;
    logic [2:0]           off_q;
    logic [31:0]          data_q;
    logic [DBUS_MASK-1:0] mask_q;

    // Timer registers.
    logic                  ctrl_en_q;
    logic                  ctrl_int_en_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [63:0]           mtime_q;
    logic [63:0]           mtime_d;
    logic [63:0]           mtimecmp_q;
    logic [31:0]           hi_shadow_q;
    logic                  int_q;

    logic        tick;
    logic        commit;
    logic        rd_mtime_lo;
    logic [31:0] rdata;

    logic unused_addr;
    assign unused_addr = ^I_dbus_addr[1:0];

    timer_tick_gen #(
        .PRESCALE_W (PRESCALE_W)
    ) u_tick_gen (
        .clk      (clk),
        .rst      (rst),
        .en       (ctrl_en_q),
        .prescale (prescale_q),
        .tick     (tick)
    );

    // ready_q is high exactly while the FSM sits in StResp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            ready_q    <= 1'b0;
            we_q       <= 1'b0;
            hit_q      <= 1'b0;
            off_q      <= '0;
            data_q     <= '0;
            mask_q     <= '0;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (I_dbus_req) begin
                        we_q   <= I_dbus_we;
                        hit_q  <= (I_dbus_addr[31:5] == BASE_ADDR[31:5]);
                        off_q  <= I_dbus_addr[4:2];
                        data_q <= I_dbus_data;
                        mask_q <= I_dbus_mask;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= StResp;
                            ready_q <= 1'b1;
                        end else begin
                            state_q    <= StWait;
                            wait_cnt_q <= WAIT_INIT;
                        end
                    end
                end
                StWait: begin
                    if (wait_cnt_q == 3'd0) begin
                        state_q <= StResp;
                        ready_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 3'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign commit      = ready_q && we_q && hit_q;
    assign rd_mtime_lo = ready_q && !we_q && hit_q && (off_q == OFF_MTIME_LO);

    // A bus write to either mtime half overrides the tick for that cycle.
    always_comb begin
        mtime_d = mtime_q;
        if (tick) begin
            mtime_d = mtime_q + 64'd1;
        end
        if (commit && (off_q == OFF_MTIME_LO)) begin
            mtime_d = {mtime_q[63:32], apply_mask(mtime_q[31:0], data_q, mask_q)};
        end
        if (commit && (off_q == OFF_MTIME_HI)) begin
            mtime_d = {apply_mask(mtime_q[63:32], data_q, mask_q), mtime_q[31:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_en_q     <= 1'b0;
            ctrl_int_en_q <= 1'b0;
            prescale_q    <= '0;
            mtime_q       <= '0;
            mtimecmp_q    <= MTIMECMP_RESET;
            hi_shadow_q   <= '0;
            int_q         <= 1'b0;
        end else begin
            if (commit && (off_q == OFF_CTRL) && mask_q[0]) begin
                ctrl_en_q     <= data_q[CTRL_EN_BIT];
                ctrl_int_en_q <= data_q[CTRL_INT_EN_BIT];
            end
            if (commit && (off_q == OFF_PRESCALE)) begin
                prescale_q <= PRESCALE_W'(apply_mask(32'(prescale_q), data_q, mask_q));
            end
            if (commit && (off_q == OFF_MTIMECMP_LO)) begin
                mtimecmp_q[31:0] <= apply_mask(mtimecmp_q[31:0], data_q, mask_q);
            end
            if (commit && (off_q == OFF_MTIMECMP_HI)) begin
                mtimecmp_q[63:32] <= apply_mask(mtimecmp_q[63:32], data_q, mask_q);
            end
            mtime_q <= mtime_d;
            // Freeze the upper half seen by a LO read so a later HI read pairs with it.
            if (rd_mtime_lo) begin
                hi_shadow_q <= mtime_q[63:32];
            end
            int_q <= ctrl_int_en_q && (mtime_q >= mtimecmp_q);
        end
    end

    always_comb begin
        rdata = '0;
        if (hit_q) begin
            case (off_q)
                OFF_CTRL:        rdata = {30'd0, ctrl_int_en_q, ctrl_en_q};
                OFF_PRESCALE:    rdata = 32'(prescale_q);
                OFF_MTIME_LO:    rdata = mtime_q[31:0];
                OFF_MTIME_HI:    rdata = hi_shadow_q;
                OFF_MTIMECMP_LO: rdata = mtimecmp_q[31:0];
                OFF_MTIMECMP_HI: rdata = mtimecmp_q[63:32];
                default:         rdata = '0;
            endcase
        end
    end

    // Read data reflects live register values during the response cycle.
    assign O_dbus_data  = ready_q ? rdata : 32'd0;
    assign O_dbus_ready = ready_q;
    assign O_timer_int  = int_q;

endmodule

// File: tb/tb_dbus_timer.sv
module tb_dbus_timer;
    import dbus_timer_pkg::*;

    localparam logic [31:0] BASE  = 32'h0200_0000;
    localparam int unsigned WAITS = 1;

    localparam logic [31:0] A_CTRL   = BASE + 32'h00;
    localparam logic [31:0] A_PRE    = BASE + 32'h04;
    localparam logic [31:0] A_MT_LO  = BASE + 32'h08;
    localparam logic [31:0] A_MT_HI  = BASE + 32'h0C;
    localparam logic [31:0] A_CMP_LO = BASE + 32'h10;
    localparam logic [31:0] A_CMP_HI = BASE + 32'h14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        I_dbus_req = 1'b0;
    logic        I_dbus_we = 1'b0;
    logic [31:0] I_dbus_addr = '0;
    logic [31:0] I_dbus_data = '0;
    logic [3:0]  I_dbus_mask = '0;
    logic [31:0] O_dbus_data;
    logic        O_dbus_ready;
    logic        O_timer_int;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    dbus_timer #(
        .BASE_ADDR   (BASE),
        .WAIT_CYCLES (WAITS),
        .PRESCALE_W  (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .I_dbus_req   (I_dbus_req),
        .I_dbus_we    (I_dbus_we),
        .I_dbus_addr  (I_dbus_addr),
        .I_dbus_data  (I_dbus_data),
        .I_dbus_mask  (I_dbus_mask),
        .O_dbus_data  (O_dbus_data),
        .O_dbus_ready (O_dbus_ready),
        .O_timer_int  (O_timer_int)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One handshake. Returns one sample after the edge that ends the response.
    task automatic bus_xfer(input logic we, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] mask, input logic [31:0] exp_rd, input string tag);
        int          lat;
        logic        seen;
        logic [31:0] exp_v;
        I_dbus_req  = 1'b1;
        I_dbus_we   = we;
        I_dbus_addr = addr;
        I_dbus_data = data;
        I_dbus_mask = mask;
        if (!we) exp_q.push_back(exp_rd);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 20) begin
            step();
            lat++;
            seen = O_dbus_ready;
        end
        I_dbus_req = 1'b0;
        I_dbus_we  = 1'b0;
        check({tag, "_ready"}, 64'(seen), 64'd1);
        if (seen) check({tag, "_lat"}, 64'(lat), 64'(WAITS + 1));
        if (!we) begin
            exp_v = exp_q.pop_front();
            if (seen) check({tag, "_rd"}, 64'(O_dbus_data), 64'(exp_v));
        end
        step();
        check({tag, "_rdy_pulse"}, 64'(O_dbus_ready), 64'd0);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask,
                      input string tag);
        bus_xfer(1'b1, addr, data, mask, 32'd0, tag);
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        bus_xfer(1'b0, addr, 32'd0, 4'h0, exp, tag);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        I_dbus_req = 1'b0;
        repeat (3) begin
            step();
            check("rst_ready", 64'(O_dbus_ready), 64'd0);
            check("rst_int", 64'(O_timer_int), 64'd0);
            check("rst_data", 64'(O_dbus_data), 64'd0);
        end
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] rdy_seen;
        rdy_seen = '0;

        // Reset values.
        do_reset();
        rd(A_CMP_LO, 32'hFFFF_FFFF, "rst_cmp_lo");
        rd(A_CMP_HI, 32'hFFFF_FFFF, "rst_cmp_hi");
        rd(A_MT_LO, 32'd0, "rst_mtime_lo");
        rd(A_CTRL, 32'd0, "rst_ctrl");

        // Held request: ready in cycles 2 and 5 only.
        I_dbus_req  = 1'b1;
        I_dbus_we   = 1'b1;
        I_dbus_addr = A_CMP_HI;
        I_dbus_data = 32'h0000_1234;
        I_dbus_mask = 4'hF;
        for (int c = 1; c <= 5; c++) begin
            step();
            rdy_seen[c] = O_dbus_ready;
        end
        I_dbus_req = 1'b0;
        I_dbus_we  = 1'b0;
        check("b2b_pattern", 64'(rdy_seen[5:1]), 64'(5'b10010));
        step();
        check("b2b_end", 64'(O_dbus_ready), 64'd0);
        rd(A_CMP_HI, 32'h0000_1234, "b2b_data");

        // Masked write.
        do_reset();
        wr(A_CMP_LO, 32'hAABB_CCDD, 4'b0101, "mask_wr");
        rd(A_CMP_LO, 32'hFFBB_FFDD, "mask_rd");

        // Prescale 3: mtime steps every 4 cycles, interrupt once mtime >= 5.
        wr(A_PRE, 32'd3, 4'hF, "pre_wr");
        wr(A_CMP_LO, 32'd5, 4'hF, "cmp_lo_wr");
        wr(A_CMP_HI, 32'd0, 4'hF, "cmp_hi_wr");
        wr(A_CTRL, 32'd3, 4'hF, "ctrl_wr");
        for (int k = 1; k <= 24; k++) begin
            step();
            check("irq_rise", 64'(O_timer_int), 64'(k >= 21));
            if (k == 20) check("mtime_at_20", dut.mtime_q, 64'd5);
        end
        rd(A_MT_LO, 32'd6, "pre_mtime");
        check("irq_hold", 64'(O_timer_int), 64'd1);
        wr(A_CMP_LO, 32'd100, 4'hF, "cmp_raise");
        check("irq_before_drop", 64'(O_timer_int), 64'd1);
        step();
        check("irq_drop", 64'(O_timer_int), 64'd0);

        // LO read just before the carry pairs with HI=0.
        wr(A_CTRL, 32'd0, 4'hF, "c1_stop");
        wr(A_MT_HI, 32'd0, 4'hF, "c1_hi");
        wr(A_MT_LO, 32'hFFFF_FFFD, 4'hF, "c1_lo");
        wr(A_PRE, 32'd0, 4'hF, "c1_pre");
        wr(A_CTRL, 32'd1, 4'hF, "c1_go");
        rd(A_MT_LO, 32'hFFFF_FFFF, "c1_rd_lo");
        rd(A_MT_HI, 32'd0, "c1_rd_hi");

        // LO read just after the carry pairs with HI=1.
        wr(A_CTRL, 32'd0, 4'hF, "c2_stop");
        wr(A_MT_HI, 32'd0, 4'hF, "c2_hi");
        wr(A_MT_LO, 32'hFFFF_FFFF, 4'hF, "c2_lo");
        wr(A_CTRL, 32'd1, 4'hF, "c2_go");
        rd(A_MT_LO, 32'd1, "c2_rd_lo");
        rd(A_MT_HI, 32'd1, "c2_rd_hi");

        // Write colliding with a tick: write wins, counting resumes next cycle.
        wr(A_MT_LO, 32'h10, 4'hF, "coll_wr");
        check("coll_commit", 64'(dut.mtime_q[31:0]), 64'h10);
        step();
        check("coll_next", 64'(dut.mtime_q[31:0]), 64'h11);
        rd(A_MT_LO, 32'h13, "coll_rd");

        // Reserved slots, out-of-window accesses, CTRL and PRESCALE width.
        wr(BASE + 32'h18, 32'hFFFF_FFFF, 4'hF, "rsv_wr");
        rd(BASE + 32'h18, 32'd0, "rsv18_rd");
        rd(BASE + 32'h1C, 32'd0, "rsv1c_rd");
        wr(BASE + 32'h30, 32'd0, 4'hF, "oow_wr");
        rd(A_CMP_LO, 32'd100, "oow_no_alias");
        rd(BASE + 32'h30, 32'd0, "oow_rd");
        rd(32'h0300_0010, 32'd0, "oow_far_rd");
        rd(A_CTRL, 32'd1, "ctrl_rd");
        wr(A_PRE, 32'h1234_5678, 4'hF, "pre_wide_wr");
        rd(A_PRE, 32'h0000_5678, "pre_wide_rd");

        // Reset during a pending write: no ready, write discarded.
        I_dbus_req  = 1'b1;
        I_dbus_we   = 1'b1;
        I_dbus_addr = A_CMP_LO;
        I_dbus_data = 32'd7;
        I_dbus_mask = 4'hF;
        step();
        rst        = 1'b1;
        I_dbus_req = 1'b0;
        I_dbus_we  = 1'b0;
        #1;
        check("midrst_ready0", 64'(O_dbus_ready), 64'd0);
        step();
        check("midrst_ready1", 64'(O_dbus_ready), 64'd0);
        step();
        check("midrst_ready2", 64'(O_dbus_ready), 64'd0);
        rst = 1'b0;
        rd(A_CMP_LO, 32'hFFFF_FFFF, "midrst_cmp");
        rd(A_CTRL, 32'd0, "midrst_ctrl");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
